frame_buffer_arbiter: RTL and testbench
=======================================

# frame_buffer_arbiter

Schedules the single memory-controller command port between the camera capture writer and the VGA display reader. Maintains a ping-pong pair of frame buffers in external RAM, generates burst byte addresses for both streams, and arbitrates with read priority plus a starvation guard for writes. Sits between the capture/display blocks and the RAM command FIFO.

## Interface
- FRAME_WORDS, 9600, 32-bit words per frame (160x120, 2 bytes/pixel)
- BASE_A, 30'h0000_0000, byte base address of buffer 0
- BASE_B, 30'h0001_0000, byte base address of buffer 1
- MAX_RD_STREAK, 4, consecutive read grants allowed while a write is pending

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- wr_req  in  1  write burst request, level, held until wr_ack
- wr_len  in  7  write burst length in words, 1..64, stable while wr_req
- wr_ack  out  1  one-cycle grant pulse to writer
- rd_req  in  1  read burst request, level, held until rd_ack
- rd_len  in  7  read burst length in words, 1..64, stable while rd_req
- rd_ack  out  1  one-cycle grant pulse to reader
- wr_frame_done  in  1  pulse: capture finished a frame
- rd_frame_start  in  1  pulse: display starting a new frame
- cmd_full  in  1  RAM command FIFO full
- cmd_en  out  1  command strobe
- cmd_instr  out  3  3'b000 write, 3'b001 read
- cmd_bl  out  6  burst length minus one
- cmd_byte_addr  out  30  burst start byte address
- wr_buf  out  1  buffer currently being written
- rd_buf  out  1  buffer currently being read
- frame_valid  out  1  at least one complete frame written

## Operation
- States: IDLE, ISSUE. IDLE samples requests; ISSUE drives the command; ISSUE always returns to IDLE.
- IDLE: if cmd_full, no grant. Else eligible = req high and stream offset < FRAME_WORDS. Both eligible: read wins unless rd_streak == MAX_RD_STREAK, then write wins. Latch instr, bl, addr; go ISSUE.
- rd_streak: +1 on each read grant while wr_req high; cleared on any write grant or when wr_req low; saturates at MAX_RD_STREAK.
- Length clamp: granted length = min(len, FRAME_WORDS - offset); cmd_bl = granted length - 1.
- Address: base(buf) + offset*4, 30-bit, no wrap; buf = wr_buf for writes, rd_buf for reads. Offset += granted length at grant.
- Offset == FRAME_WORDS: stream not eligible; request stays pending, no ack, until its frame event.
- wr_frame_done: wr_offset <= 0; done_buf <= wr_buf; wr_buf toggles; frame_valid <= 1.
- rd_frame_start: rd_offset <= 0; rd_buf <= done_buf (<= current wr_buf if wr_frame_done same cycle).
- Frame event in same cycle as a grant of that stream: command uses pre-event address; offset ends at 0 (event wins over increment).
- Reads granted before frame_valid (rd_buf = 1, undefined data); display masks with frame_valid.

## Timing
- Reset values: cmd_en 0, cmd_instr 0, cmd_bl 0, cmd_byte_addr 0, wr_ack 0, rd_ack 0, wr_buf 0, rd_buf 1, frame_valid 0; offsets, rd_streak, done_buf 0; state IDLE.
- Grant latency: request sampled high in IDLE cycle N -> cmd_en, ack, cmd_* valid in cycle N+1 (single cycle).
- Requester drops or re-presents req from cycle N+2; IDLE re-samples at N+2. Max one command per two cycles.
- cmd_full only sampled in IDLE; a command already in ISSUE is driven regardless.
- cmd_instr/cmd_bl/cmd_byte_addr hold last value outside ISSUE.
- rst mid-ISSUE: cmd_en low next cycle; partial state discarded.

## Test plan
- Single write wr_len=40 after reset -> cycle+1: cmd_en=1, instr=000, bl=39, addr=0x0, wr_ack=1; next write addr=0xA0.
- rd_req and wr_req both held continuously (len 8) -> grant sequence R,R,R,R,W,R,R,R,R,W; no stream starves.
- wr_offset=9590, wr_len=40 -> bl=9, addr=0x95D8; further wr_req not acked until wr_frame_done, then addr=BASE_B.
- wr_frame_done and rd_frame_start same cycle with wr_buf=0 -> wr_buf=1, rd_buf=0, frame_valid=1, rd_offset=0.
- cmd_full=1 with both requests high for 10 cycles -> no cmd_en/ack; cmd_full falls -> read granted next cycle+1.
- rst asserted during ISSUE -> next cycle all outputs at reset values, next write addr=0x0.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// Shares the RAM command port between the capture writer and the display reader.
// Read priority with a write starvation guard; ping-pong frame buffers with burst address generation.
module frame_buffer_arbiter #(
  parameter int unsigned FRAME_WORDS   = 9600,
  parameter logic [29:0] BASE_A        = 30'h0000_0000,
  parameter logic [29:0] BASE_B        = 30'h0001_0000,
  parameter int unsigned MAX_RD_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [6:0]  wr_len,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [6:0]  rd_len,
  output logic        rd_ack,
  input  logic        wr_frame_done,
  input  logic        rd_frame_start,
  input  logic        cmd_full,
  output logic        cmd_en,
  output logic [2:0]  cmd_instr,
  output logic [5:0]  cmd_bl,
  output logic [29:0] cmd_byte_addr,
  output logic        wr_buf,
  output logic        rd_buf,
  output logic        frame_valid
);

  localparam int unsigned OFF_W    = $clog2(FRAME_WORDS + 1);
  localparam int unsigned LEN_W    = 7;
  localparam int unsigned STREAK_W = $clog2(MAX_RD_STREAK + 1);
  localparam int unsigned ADDR_W   = 30;
  localparam logic [2:0]  INSTR_WR = 3'b000;
  localparam logic [2:0]  INSTR_RD = 3'b001;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state;
  logic [OFF_W-1:0]    wr_offset;
  logic [OFF_W-1:0]    rd_offset;
  logic [STREAK_W-1:0] rd_streak;
  logic                done_buf;

  logic                wr_elig;
  logic                rd_elig;
  logic                grant_wr;
  logic                grant_rd;
  logic [OFF_W-1:0]    wr_room;
  logic [OFF_W-1:0]    rd_room;
  logic [LEN_W-1:0]    wr_glen;
  logic [LEN_W-1:0]    rd_glen;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;

  // Burst clamping to the end of the frame and start address per stream
  always_comb begin
    wr_room = OFF_W'(FRAME_WORDS) - wr_offset;
    rd_room = OFF_W'(FRAME_WORDS) - rd_offset;
    wr_glen = (OFF_W'(wr_len) > wr_room) ? LEN_W'(wr_room) : wr_len;
    rd_glen = (OFF_W'(rd_len) > rd_room) ? LEN_W'(rd_room) : rd_len;
    wr_addr = (wr_buf ? BASE_B : BASE_A) + ADDR_W'({wr_offset, 2'b00});
    rd_addr = (rd_buf ? BASE_B : BASE_A) + ADDR_W'({rd_offset, 2'b00});
  end

  // Arbitration: read wins unless writes have waited through a full read streak
  always_comb begin
    wr_elig  = wr_req && (wr_offset < OFF_W'(FRAME_WORDS));
    rd_elig  = rd_req && (rd_offset < OFF_W'(FRAME_WORDS));
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if ((state == IDLE) && !cmd_full) begin
      if (wr_elig && rd_elig) begin
        if (rd_streak == STREAK_W'(MAX_RD_STREAK)) grant_wr = 1'b1;
        else                                       grant_rd = 1'b1;
      end else begin
        grant_wr = wr_elig;
        grant_rd = rd_elig;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cmd_en        <= 1'b0;
      cmd_instr     <= 3'b000;
      cmd_bl        <= 6'd0;
      cmd_byte_addr <= '0;
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      wr_buf        <= 1'b0;
      rd_buf        <= 1'b1;
      frame_valid   <= 1'b0;
      wr_offset     <= '0;
      rd_offset     <= '0;
      rd_streak     <= '0;
      done_buf      <= 1'b0;
    end else begin
      cmd_en <= 1'b0;
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;

      if (state == IDLE) begin
        if (grant_wr) begin
          state         <= ISSUE;
          cmd_en        <= 1'b1;
          wr_ack        <= 1'b1;
          cmd_instr     <= INSTR_WR;
          cmd_bl        <= 6'(wr_glen - LEN_W'(1));
          cmd_byte_addr <= wr_addr;
          wr_offset     <= wr_offset + OFF_W'(wr_glen);
        end else if (grant_rd) begin
          state         <= ISSUE;
          cmd_en        <= 1'b1;
          rd_ack        <= 1'b1;
          cmd_instr     <= INSTR_RD;
          cmd_bl        <= 6'(rd_glen - LEN_W'(1));
          cmd_byte_addr <= rd_addr;
          rd_offset     <= rd_offset + OFF_W'(rd_glen);
        end
      end else begin
        state <= IDLE;
      end

      if (grant_wr || !wr_req) begin
        rd_streak <= '0;
      end else if (grant_rd && (rd_streak != STREAK_W'(MAX_RD_STREAK))) begin
        rd_streak <= rd_streak + STREAK_W'(1);
      end

      // Frame events override any same-cycle offset advance
      if (wr_frame_done) begin
        wr_offset   <= '0;
        done_buf    <= wr_buf;
        wr_buf      <= ~wr_buf;
        frame_valid <= 1'b1;
      end
      if (rd_frame_start) begin
        rd_offset <= '0;
        rd_buf    <= wr_frame_done ? wr_buf : done_buf;
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Scoreboard bench for frame_buffer_arbiter: a frame-level reference model queues expected
// per-cycle status and commands; an independent monitor pops and compares.
module tb_frame_buffer_arbiter;

  localparam int FW   = 9600;
  localparam int BA   = 32'h0000_0000;
  localparam int BB   = 32'h0001_0000;
  localparam int MAXS = 4;

  logic        clk;
  logic        rst;
  logic        wr_req;
  logic [6:0]  wr_len;
  logic        wr_ack;
  logic        rd_req;
  logic [6:0]  rd_len;
  logic        rd_ack;
  logic        wr_frame_done;
  logic        rd_frame_start;
  logic        cmd_full;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        wr_buf;
  logic        rd_buf;
  logic        frame_valid;

  frame_buffer_arbiter dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_len(wr_len), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_len(rd_len), .rd_ack(rd_ack),
    .wr_frame_done(wr_frame_done), .rd_frame_start(rd_frame_start),
    .cmd_full(cmd_full), .cmd_en(cmd_en), .cmd_instr(cmd_instr),
    .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
    .wr_buf(wr_buf), .rd_buf(rd_buf), .frame_valid(frame_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int instr;
    int bl;
    int addr;
  } cmd_t;

  typedef struct {
    int   en;
    int   wa;
    int   ra;
    int   wb;
    int   rb;
    int   fv;
    cmd_t last;
  } stat_t;

  stat_t stat_q[$];
  cmd_t  cmd_q[$];
  byte   glog[$];

  int tests;
  int fails;

  // Reference model state: frame progress per stream, buffer roles, pending write streak
  int   m_woff, m_roff, m_wbuf, m_rbuf, m_done, m_fv, m_streak, m_issue;
  cmd_t m_last;
  int   last_grant;  // 0 none, 1 write, 2 read

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Evaluate the model for the coming clock edge, queue expectations, then advance one cycle
  task automatic tick();
    stat_t s;
    cmd_t  c;
    int    gw, gr, glen, old_wbuf, old_done, we, re;
    gw = 0;
    gr = 0;
    if (rst) begin
      m_woff = 0; m_roff = 0; m_wbuf = 0; m_rbuf = 1; m_done = 0;
      m_fv = 0; m_streak = 0; m_issue = 0;
      m_last = '{0, 0, 0};
    end else begin
      if (m_issue == 0 && !cmd_full) begin
        we = (wr_req && m_woff < FW) ? 1 : 0;
        re = (rd_req && m_roff < FW) ? 1 : 0;
        if (we == 1 && re == 1) begin
          if (m_streak >= MAXS) gw = 1;
          else                  gr = 1;
        end else begin
          gw = we;
          gr = re;
        end
      end
      if (gw == 1) begin
        glen    = imin(int'(wr_len), FW - m_woff);
        c.instr = 0;
        c.bl    = glen - 1;
        c.addr  = (m_wbuf == 1 ? BB : BA) + 4 * m_woff;
        m_woff += glen;
        cmd_q.push_back(c);
        m_last = c;
      end
      if (gr == 1) begin
        glen    = imin(int'(rd_len), FW - m_roff);
        c.instr = 1;
        c.bl    = glen - 1;
        c.addr  = (m_rbuf == 1 ? BB : BA) + 4 * m_roff;
        m_roff += glen;
        cmd_q.push_back(c);
        m_last = c;
      end
      if (gw == 1 || !wr_req) m_streak = 0;
      else if (gr == 1)       m_streak = imin(m_streak + 1, MAXS);
      old_wbuf = m_wbuf;
      old_done = m_done;
      if (wr_frame_done) begin
        m_woff = 0;
        m_done = old_wbuf;
        m_wbuf = 1 - old_wbuf;
        m_fv   = 1;
      end
      if (rd_frame_start) begin
        m_roff = 0;
        m_rbuf = wr_frame_done ? old_wbuf : old_done;
      end
      m_issue = (gw == 1 || gr == 1) ? 1 : 0;
    end
    s.en = m_issue; s.wa = gw; s.ra = gr;
    s.wb = m_wbuf;  s.rb = m_rbuf; s.fv = m_fv;
    s.last = m_last;
    stat_q.push_back(s);
    last_grant = (gw == 1) ? 1 : (gr == 1) ? 2 : 0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against queued expectations after every edge
  initial begin
    stat_t s;
    cmd_t  c;
    forever begin
      @(posedge clk);
      #1;
      if (stat_q.size() != 0) begin
        s = stat_q.pop_front();
        chk("cmd_en",        32'(cmd_en),        32'(s.en));
        chk("wr_ack",        32'(wr_ack),        32'(s.wa));
        chk("rd_ack",        32'(rd_ack),        32'(s.ra));
        chk("wr_buf",        32'(wr_buf),        32'(s.wb));
        chk("rd_buf",        32'(rd_buf),        32'(s.rb));
        chk("frame_valid",   32'(frame_valid),   32'(s.fv));
        chk("cmd_instr",     32'(cmd_instr),     32'(s.last.instr));
        chk("cmd_bl",        32'(cmd_bl),        32'(s.last.bl));
        chk("cmd_byte_addr", 32'(cmd_byte_addr), 32'(s.last.addr));
        if (cmd_en === 1'b1) begin
          if (cmd_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_cmd: got cmd_en=1 expected no command at %0t", $time);
          end else begin
            c = cmd_q.pop_front();
            chk("sb_instr", 32'(cmd_instr),     32'(c.instr));
            chk("sb_bl",    32'(cmd_bl),        32'(c.bl));
            chk("sb_addr",  32'(cmd_byte_addr), 32'(c.addr));
          end
          glog.push_back((cmd_instr == 3'b001) ? byte'("R") : byte'("W"));
        end
      end
    end
  end

  task automatic idle_inputs();
    wr_req = 1'b0; wr_len = 7'd1; rd_req = 1'b0; rd_len = 7'd1;
    wr_frame_done = 1'b0; rd_frame_start = 1'b0; cmd_full = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Raise one request and tick until granted; returns in the ISSUE cycle with the request dropped
  task automatic do_req(input int is_rd, input int len);
    int got;
    got = 0;
    if (is_rd == 1) begin rd_req = 1'b1; rd_len = 7'(len); end
    else            begin wr_req = 1'b1; wr_len = 7'(len); end
    for (int k = 0; k < 20 && got == 0; k++) begin
      tick();
      if (last_grant == (is_rd == 1 ? 2 : 1)) got = 1;
    end
    if (got == 0) begin
      tests++;
      fails++;
      $display("FAIL grant_timeout: got no grant expected grant for %s", is_rd == 1 ? "read" : "write");
    end
    if (is_rd == 1) rd_req = 1'b0;
    else            wr_req = 1'b0;
  endtask

  initial begin
    string exp_seq;
    tests = 0;
    fails = 0;
    last_grant = 0;
    rst = 1'b1;
    idle_inputs();
    do_reset();

    chk("reset_cmd_en", 32'(cmd_en), 32'd0);
    chk("reset_rd_buf", 32'(rd_buf), 32'd1);
    chk("reset_wr_buf", 32'(wr_buf), 32'd0);
    chk("reset_fv",     32'(frame_valid), 32'd0);

    // Single write after reset, then a follow-on write
    do_req(0, 40);
    chk("t1_cmd_en", 32'(cmd_en), 32'd1);
    chk("t1_instr",  32'(cmd_instr), 32'd0);
    chk("t1_bl",     32'(cmd_bl), 32'd39);
    chk("t1_addr",   32'(cmd_byte_addr), 32'h0);
    chk("t1_wr_ack", 32'(wr_ack), 32'd1);
    tick();
    do_req(0, 40);
    chk("t1_addr2",  32'(cmd_byte_addr), 32'hA0);

    // Reset during ISSUE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_cmd_en", 32'(cmd_en), 32'd0);
    chk("t6_wr_ack", 32'(wr_ack), 32'd0);
    chk("t6_addr",   32'(cmd_byte_addr), 32'h0);
    chk("t6_bl",     32'(cmd_bl), 32'd0);
    chk("t6_rd_buf", 32'(rd_buf), 32'd1);
    do_req(0, 40);
    chk("t6_addr2",  32'(cmd_byte_addr), 32'h0);
    tick();

    // Both streams held: starvation guard sequence
    do_reset();
    #2;
    glog.delete();
    wr_req = 1'b1; wr_len = 7'd8; rd_req = 1'b1; rd_len = 7'd8;
    for (int k = 0; k < 20; k++) tick();
    #2;
    exp_seq = "RRRRWRRRRW";
    chk("t2_count", 32'(glog.size()), 32'd10);
    for (int k = 0; k < 10 && k < glog.size(); k++)
      chk("t2_order", 32'(glog[k]), 32'(exp_seq[k]));
    idle_inputs();
    tick();

    // Command FIFO full blocks grants; read wins once it drains
    do_reset();
    cmd_full = 1'b1;
    wr_req = 1'b1; wr_len = 7'd8; rd_req = 1'b1; rd_len = 7'd8;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t5_no_cmd", 32'(cmd_en), 32'd0);
    end
    cmd_full = 1'b0;
    tick();
    chk("t5_rd_ack", 32'(rd_ack), 32'd1);
    chk("t5_instr",  32'(cmd_instr), 32'd1);
    idle_inputs();
    tick();

    // Simultaneous frame events
    do_reset();
    wr_frame_done = 1'b1; rd_frame_start = 1'b1;
    tick();
    wr_frame_done = 1'b0; rd_frame_start = 1'b0;
    chk("t4_wr_buf", 32'(wr_buf), 32'd1);
    chk("t4_rd_buf", 32'(rd_buf), 32'd0);
    chk("t4_fv",     32'(frame_valid), 32'd1);
    do_req(1, 5);
    chk("t4_rd_addr", 32'(cmd_byte_addr), 32'h0);
    tick();

    // End-of-frame clamp and hold-off until the frame event
    do_reset();
    for (int k = 0; k < 149; k++) begin
      do_req(0, 64);
      tick();
    end
    do_req(0, 54);
    tick();
    do_req(0, 40);
    chk("t3_bl",   32'(cmd_bl), 32'd9);
    chk("t3_addr", 32'(cmd_byte_addr), 32'h95D8);
    tick();
    wr_req = 1'b1; wr_len = 7'd40;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t3_no_ack", 32'(wr_ack), 32'd0);
    end
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    do_req(0, 40);
    chk("t3_addr_b", 32'(cmd_byte_addr), 32'h10000);
    chk("t3_wr_buf", 32'(wr_buf), 32'd1);
    tick();

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      if (!wr_req || last_grant == 1) begin
        wr_req = ($urandom_range(0, 9) < 6);
        wr_len = 7'($urandom_range(1, 64));
      end
      if (!rd_req || last_grant == 2) begin
        rd_req = ($urandom_range(0, 9) < 6);
        rd_len = 7'($urandom_range(1, 64));
      end
      wr_frame_done  = (m_woff == FW) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2999) == 0);
      rd_frame_start = (m_roff == FW) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2999) == 0);
      cmd_full       = ($urandom_range(0, 4) == 0);
      rst            = ($urandom_range(0, 1999) == 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    tick();
    #3;
    chk("sb_drained", 32'(cmd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
